// File: rtl/loopback_skew_prober.sv
// Far-end loopback test master: flushes the line, sends a probe word to measure
// round-trip lag, then streams PRBS-8 words and counts mismatches at that lag.
module loopback_skew_prober #(
   parameter int unsigned MAX_LAG = 7,
   parameter int unsigned N_CHECK = 64,
   parameter logic [7:0]  MARKER  = 8'hA5,
   parameter logic [7:0]  SEED    = 8'h01
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [7:0] rx_data_i,
   output logic [7:0] tx_data_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       locked_o,
   output logic       timeout_o,
   output logic [3:0] lag_o,
   output logic [7:0] err_cnt_o,
   output logic       pass_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_FLUSH, S_PROBE, S_WAIT, S_CHECK, S_DRAIN, S_DONE
   } state_t;

   localparam logic [7:0] MAX_LAG_W = 8'(MAX_LAG);
   localparam logic [7:0] N_CHECK_W = 8'(N_CHECK);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] cmp_q, cmp_d;
   logic [7:0] lfsr_q, lfsr_d;
   logic [7:0] tx_q, tx_d;
   logic       locked_q, locked_d;
   logic       timeout_q, timeout_d;
   logic [3:0] lag_q, lag_d;
   logic [7:0] err_q, err_d;

   logic [7:0] hist_q [0:MAX_LAG-1];
   logic       hvld_q [0:MAX_LAG-1];

   logic [7:0] sel_word;
   logic       sel_vld;
   logic       cmp_en;

   function automatic logic [7:0] prbs_next(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   // tx_q itself is history slot 0; it holds a check word exactly while in CHECK
   always_comb begin
      sel_word = tx_q;
      sel_vld  = (state_q == S_CHECK);
      for (int k = 1; k <= int'(MAX_LAG); k++) begin
         if (lag_q == 4'(k)) begin
            sel_word = hist_q[k-1];
            sel_vld  = hvld_q[k-1];
         end
      end
   end

   assign cmp_en = ((state_q == S_CHECK) || (state_q == S_DRAIN)) && sel_vld;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cmp_d     = cmp_q;
      lfsr_d    = lfsr_q;
      tx_d      = 8'h00;
      locked_d  = locked_q;
      timeout_d = timeout_q;
      lag_d     = lag_q;
      err_d     = err_q;

      if (cmp_en) begin
         cmp_d = cmp_q + 8'd1;
         if ((rx_data_i != sel_word) && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
         end
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d   = S_FLUSH;
               cnt_d     = 8'd0;
               cmp_d     = 8'd0;
               locked_d  = 1'b0;
               timeout_d = 1'b0;
               lag_d     = 4'd0;
               err_d     = 8'd0;
            end
         end
         S_FLUSH: begin
            if (cnt_q == MAX_LAG_W) begin
               state_d = S_PROBE;
               cnt_d   = 8'd0;
               tx_d    = MARKER;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_PROBE, S_WAIT: begin
            if (rx_data_i == MARKER) begin
               state_d  = S_CHECK;
               lag_d    = cnt_q[3:0];
               locked_d = 1'b1;
               tx_d     = SEED;
               lfsr_d   = prbs_next(SEED);
               cnt_d    = 8'd1;
               cmp_d    = 8'd0;
            end else if (cnt_q == MAX_LAG_W) begin
               state_d   = S_DONE;
               timeout_d = 1'b1;
            end else begin
               state_d = S_WAIT;
               cnt_d   = cnt_q + 8'd1;
            end
         end
         S_CHECK: begin
            // lfsr_q always holds the word to be sent after the current one
            if (cnt_q == N_CHECK_W) begin
               state_d = S_DRAIN;
            end else begin
               tx_d   = lfsr_q;
               lfsr_d = prbs_next(lfsr_q);
               cnt_d  = cnt_q + 8'd1;
            end
         end
         S_DRAIN: begin
            if (cmp_q == N_CHECK_W) begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= 8'd0;
         cmp_q     <= 8'd0;
         lfsr_q    <= SEED;
         tx_q      <= 8'h00;
         locked_q  <= 1'b0;
         timeout_q <= 1'b0;
         lag_q     <= 4'd0;
         err_q     <= 8'd0;
         for (int k = 0; k < int'(MAX_LAG); k++) begin
            hist_q[k] <= 8'h00;
            hvld_q[k] <= 1'b0;
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cmp_q     <= cmp_d;
         lfsr_q    <= lfsr_d;
         tx_q      <= tx_d;
         locked_q  <= locked_d;
         timeout_q <= timeout_d;
         lag_q     <= lag_d;
         err_q     <= err_d;
         hist_q[0] <= tx_q;
         hvld_q[0] <= (state_q == S_CHECK);
         for (int k = 1; k < int'(MAX_LAG); k++) begin
            hist_q[k] <= hist_q[k-1];
            hvld_q[k] <= hvld_q[k-1];
         end
      end
   end

   assign tx_data_o = tx_q;
   assign busy_o    = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done_o    = (state_q == S_DONE);
   assign locked_o  = locked_q;
   assign timeout_o = timeout_q;
   assign lag_o     = lag_q;
   assign err_cnt_o = err_q;
   assign pass_o    = done_o && locked_q && (err_q == 8'd0);

endmodule

// File: tb/tb_loopback_skew_prober.sv
// Bench for loopback_skew_prober: a modelled loopback channel with configurable
// lag, inversion, stuck-zero and word corruption, checked against predicted results.
module tb_loopback_skew_prober;

   localparam int         MAX_LAG = 7;
   localparam int         N_CHECK = 64;
   localparam logic [7:0] MARKER  = 8'hA5;
   localparam logic [7:0] SEED    = 8'h01;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] rx_data;
   logic [7:0] tx_data;
   logic       busy, done, locked, timeout, pass;
   logic [3:0] lag;
   logic [7:0] err_cnt;

   int checkCount = 0;
   int errorCount = 0;
   int edgeCnt    = 0;

   int         chanLag  = 0;
   bit         chanZero = 1'b0;
   bit         chanInv  = 1'b0;
   int         sEdge    = 32'h3FFF_FFFF;
   logic [7:0] corr  [0:1023];
   logic [7:0] dline [0:15];
   logic [7:0] seq   [0:N_CHECK-1];
   logic [7:0] txMod;
   logic [7:0] chanOut;
   int         relC;

   loopback_skew_prober #(
      .MAX_LAG(MAX_LAG), .N_CHECK(N_CHECK), .MARKER(MARKER), .SEED(SEED)
   ) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .rx_data_i(rx_data),
      .tx_data_o(tx_data), .busy_o(busy), .done_o(done), .locked_o(locked),
      .timeout_o(timeout), .lag_o(lag), .err_cnt_o(err_cnt), .pass_o(pass)
   );

   always #5 clk = ~clk;

   // Channel delay line, one stage per cycle of lag
   always @(posedge clk) begin
      edgeCnt  <= edgeCnt + 1;
      dline[0] <= txMod;
      for (int k = 1; k < 16; k++) dline[k] <= dline[k-1];
   end

   // Corruption is keyed to the cycle number relative to the start edge
   always_comb begin
      relC    = edgeCnt - sEdge;
      txMod   = tx_data;
      if (relC >= 0 && relC < 1024) txMod = tx_data ^ corr[relC];
      chanOut = (chanLag == 0) ? txMod : dline[chanLag-1];
      if (chanZero)     rx_data = 8'h00;
      else if (chanInv) rx_data = ~chanOut;
      else              rx_data = chanOut;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clearCorr();
      for (int i = 0; i < 1024; i++) corr[i] = 8'h00;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_tx"}, 32'(tx_data), 0);
      checkOutput({tag, "_busy"}, 32'(busy), 0);
      checkOutput({tag, "_done"}, 32'(done), 0);
      checkOutput({tag, "_locked"}, 32'(locked), 0);
      checkOutput({tag, "_timeout"}, 32'(timeout), 0);
      checkOutput({tag, "_lag"}, 32'(lag), 0);
      checkOutput({tag, "_err"}, 32'(err_cnt), 0);
      checkOutput({tag, "_pass"}, 32'(pass), 0);
   endtask

   // One complete run: configure channel, pulse start, follow the run, check results
   task automatic applyStimulus(input int lagIn, input bit zeroIn, input bit invIn,
                                input int nFlips, input int fixIdx, input logic [7:0] fixMask);
      bit lockExp;
      int base, flips, idx, expDone, rel;
      @(negedge clk);
      chanLag  = lagIn;
      chanZero = zeroIn;
      chanInv  = invIn;
      clearCorr();
      lockExp = !zeroIn && !invIn && (lagIn <= MAX_LAG);
      base    = MAX_LAG + 2 + lagIn;
      flips   = 0;
      if (lockExp) begin
         if (fixIdx >= 0) begin
            corr[base + fixIdx] = fixMask;
            flips++;
         end
         for (int n = 0; n < nFlips; n++) begin
            idx = $urandom_range(0, N_CHECK - 1);
            while (corr[base + idx] != 8'h00) idx = $urandom_range(0, N_CHECK - 1);
            corr[base + idx] = 8'($urandom_range(1, 255));
            flips++;
         end
      end
      expDone = lockExp ? (base + N_CHECK + lagIn + 1) : (2 * MAX_LAG + 2);
      sEdge = edgeCnt + 1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("startBusy", 32'(busy), 1);
      checkOutput("startLockedClr", 32'(locked), 0);
      checkOutput("startErrClr", 32'(err_cnt), 0);
      rel = 0;
      for (int k = 0; k < 3000; k++) begin
         @(posedge clk);
         #1;
         rel = edgeCnt - sEdge;
         if (lockExp && rel >= base && rel < base + N_CHECK)
            checkOutput("txWord", 32'(tx_data), 32'(seq[rel - base]));
         if (done) break;
      end
      checkOutput("doneEdge", 32'(rel), 32'(expDone));
      checkOutput("done", 32'(done), 1);
      checkOutput("busyEnd", 32'(busy), 0);
      checkOutput("txEnd", 32'(tx_data), 0);
      checkOutput("locked", 32'(locked), 32'(lockExp));
      checkOutput("timeout", 32'(timeout), 32'(!lockExp));
      checkOutput("lag", 32'(lag), lockExp ? 32'(lagIn) : 0);
      checkOutput("errCnt", 32'(err_cnt), lockExp ? 32'((flips > 255) ? 255 : flips) : 0);
      checkOutput("pass", 32'(pass), 32'(lockExp && flips == 0));
   endtask

   initial begin
      logic [7:0] s;
      int         rel;
      s = SEED;
      for (int i = 0; i < N_CHECK; i++) begin
         seq[i] = s;
         s = {s[6:0], ^(s & 8'hB8)};
      end
      clearCorr();
      for (int k = 0; k < 16; k++) dline[k] = 8'h00;
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkAllZero("reset");
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] wire loop, 3-flop loop, stuck zero");
      applyStimulus(0, 1'b0, 1'b0, 0, -1, 8'h00);
      applyStimulus(3, 1'b0, 1'b0, 0, -1, 8'h00);
      applyStimulus(0, 1'b1, 1'b0, 0, -1, 8'h00);

      $display("[TB] single corrupted word, inverted loop, lag beyond range");
      applyStimulus(1, 1'b0, 1'b0, 0, 9, 8'h01);
      applyStimulus(1, 1'b0, 1'b1, 0, -1, 8'h00);
      applyStimulus(MAX_LAG, 1'b0, 1'b0, 0, -1, 8'h00);
      applyStimulus(MAX_LAG + 1, 1'b0, 1'b0, 0, -1, 8'h00);

      $display("[TB] reset mid-check");
      @(negedge clk);
      chanLag = 2; chanZero = 1'b0; chanInv = 1'b0;
      clearCorr();
      sEdge = edgeCnt + 1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 0; k < 500; k++) begin
         @(posedge clk);
         if (edgeCnt - sEdge >= MAX_LAG + 2 + 2 + 10) break;
      end
      @(negedge clk);
      checkOutput("midCheckLocked", 32'(locked), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkAllZero("midReset");
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(2, 1'b0, 1'b0, 0, -1, 8'h00);

      $display("[TB] start held high");
      @(negedge clk);
      chanLag = 1; chanZero = 1'b0; chanInv = 1'b0;
      clearCorr();
      sEdge = edgeCnt + 1;
      start = 1'b1;
      rel = 0;
      for (int k = 0; k < 3000; k++) begin
         @(posedge clk);
         #1;
         rel = edgeCnt - sEdge;
         if (done) break;
      end
      checkOutput("heldDoneEdge", 32'(rel), 32'(MAX_LAG + 3 + N_CHECK + 1 + 1));
      checkOutput("heldPass", 32'(pass), 1);
      @(posedge clk);
      #1;
      checkOutput("restartBusy", 32'(busy), 1);
      checkOutput("restartDone", 32'(done), 0);
      checkOutput("restartLockedClr", 32'(locked), 0);
      start = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(posedge clk);
         #1;
         if (done) break;
      end
      checkOutput("restartRunDone", 32'(done), 1);
      checkOutput("restartRunPass", 32'(pass), 1);
      checkOutput("restartRunLag", 32'(lag), 1);

      $display("[TB] randomized runs");
      for (int r = 0; r < 12; r++) begin
         repeat ($urandom_range(0, 5)) @(posedge clk);
         applyStimulus($urandom_range(0, MAX_LAG + 2), ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 7) == 0), $urandom_range(0, 3), -1, 8'h00);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
